word_uart_tx: RTL and testbench

- Parallel-to-serial drain path for a WIDTH-bit datapath word.
- Accepts one word via valid/ready handshake and sends it on a UART line as WIDTH/8 bytes, 8N1 framing, least-significant byte first.
- Sits between the CPU output path (value held in a datapath register) and the board TX pin.
- Counterpart to the host-to-core receive path.

---
 rtl/word_uart_tx.sv | 127 ++++++++++++
 tb/tb_word_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_uart_tx.sv
// Word-wide UART transmitter: sends a WIDTH-bit word as WIDTH/8 bytes, 8N1, LSB byte first.
// Define WORD_UART_TX_PARITY_EN to insert an even-parity bit after the data bits of each byte.
module word_uart_tx #(
  parameter int WIDTH       = 32,
  parameter int CLK_PER_BIT = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             txd,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = $clog2(CLK_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [BYTE_W-1:0]  byte_cnt, byte_cnt_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [BAUD_W-1:0]  baud_cnt, baud_cnt_n;
  logic               txd_n;
  logic               busy_n;
  logic               bit_end;
  logic [7:0]         tx_byte;

  assign ready   = (state == IDLE);
  assign bit_end = (baud_cnt == BAUD_W'(CLK_PER_BIT - 1));

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    byte_cnt_n = byte_cnt;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (valid) begin
          state_n    = START;
          shreg_n    = data;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef WORD_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
            state_n = IDLE;
          end else begin
            state_n    = START;
            byte_cnt_n = byte_cnt + 1'b1;
            shreg_n    = shreg >> 8;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // txd and busy are registered, so decode them from the state being entered.
  always_comb begin
    tx_byte = shreg_n[7:0];
    txd_n   = 1'b1;
    busy_n  = (state_n != IDLE);
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_byte[bit_cnt_n];
      PARITY:  txd_n = ^tx_byte;
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      byte_cnt <= byte_cnt_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      txd      <= txd_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: a 32-bit instance decoded by a line monitor against a byte queue,
// plus an 8-bit instance for single-byte framing and the optional parity bit.
module tb_word_uart_tx;

  localparam int CPB = 4;
`ifdef WORD_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int WORD_CYC = FRAME_BITS * CPB * 4;
  localparam int BYTE_CYC = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        ready, txd, busy;
  logic [7:0]  data8;
  logic        valid8;
  logic        ready8, txd8, busy8;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  word_uart_tx #(.WIDTH(32), .CLK_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .ready(ready), .txd(txd), .busy(busy)
  );

  word_uart_tx #(.WIDTH(8), .CLK_PER_BIT(CPB)) u_dut8 (
    .clk(clk), .rst(rst), .data(data8), .valid(valid8),
    .ready(ready8), .txd(txd8), .busy(busy8)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    push_word(w);
    data  = w;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_busy_drop(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      cyc++;
      tick();
    end
  endtask

  task automatic send8(input logic [7:0] b, output int cyc, output logic [7:0] got,
                       output logic bit9);
    data8  = b;
    valid8 = 1'b1;
    tick();
    valid8 = 1'b0;
    cyc  = 0;
    got  = '0;
    bit9 = 1'bx;
    while (busy8 === 1'b1 && cyc < 500) begin
      if (cyc % CPB == CPB / 2) begin
        if (cyc / CPB >= 1 && cyc / CPB <= 8) got[cyc/CPB-1] = txd8;
        if (cyc / CPB == 9) bit9 = txd8;
      end
      cyc++;
      tick();
    end
  endtask

  // scoreboard: decode frames on txd, sampling mid-bit on the falling edge
  initial begin
    bit         mon_active;
    int         mcnt;
    int         idx;
    logic [7:0] mon_byte;
    mon_active = 1'b0;
    mcnt       = 0;
    mon_byte   = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active) begin
          if (txd === 1'b0) begin
            mon_active = 1'b1;
            mcnt       = 0;
          end
        end else begin
          mcnt++;
        end
        if (mon_active && (mcnt % CPB == CPB / 2)) begin
          idx = mcnt / CPB;
          if (idx == 0) begin
            check("start_bit", txd, 1'b0);
          end else if (idx <= 8) begin
            mon_byte[idx-1] = txd;
          end else if (idx < FRAME_BITS - 1) begin
            check("parity_bit", txd, ^mon_byte);
          end else begin
            check("stop_bit", txd, 1'b1);
            if (exp_q.size() == 0) begin
              check("unexpected_byte", mon_byte, 32'hffff_ffff);
            end else begin
              check("byte", mon_byte, exp_q.pop_front());
            end
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int         cyc;
    int         changes;
    int         ready_hits;
    logic       last_txd;
    logic [7:0] got;
    logic       bit9;

    rst    = 1'b1;
    data   = '0;
    valid  = 1'b0;
    data8  = '0;
    valid8 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state and a quiet line
    check("reset_txd", txd, 1'b1);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready8", ready8, 1'b1);
    changes  = 0;
    last_txd = txd;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== last_txd) changes++;
      last_txd = txd;
    end
    check("idle_no_toggle", changes, 0);

    // single word
    send_word(32'h1234_A55A);
    check("first_start_low", txd, 1'b0);
    wait_busy_drop(cyc);
    check("single_busy_cycles", cyc, WORD_CYC);
    check("single_ready_after", ready, 1'b1);
    check("single_txd_idle", txd, 1'b1);
    tick();

    // back-to-back words with valid held high
    push_word(32'hFFFF_0000);
    push_word(32'h0000_00FF);
    data  = 32'hFFFF_0000;
    valid = 1'b1;
    tick();
    data = 32'h0000_00FF;
    wait_busy_drop(cyc);
    check("b2b_first_cycles", cyc, WORD_CYC);
    check("b2b_gap_txd_high", txd, 1'b1);
    check("b2b_gap_ready", ready, 1'b1);
    tick();
    valid = 1'b0;
    check("b2b_second_busy", busy, 1'b1);
    check("b2b_second_start", txd, 1'b0);
    wait_busy_drop(cyc);
    check("b2b_second_cycles", cyc, WORD_CYC);
    check("b2b_queue_drained", exp_q.size(), 0);
    tick();

    // mid-frame reset during the third byte's data bits; only two bytes complete
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    data  = 32'h1122_3344;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (2 * BYTE_CYC + CPB + 9) tick();
    check("midframe_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_txd", txd, 1'b1);
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_queue", exp_q.size(), 0);
    tick();
    send_word(32'hDEAD_BEEF);
    wait_busy_drop(cyc);
    check("after_abort_cycles", cyc, WORD_CYC);
    tick();

    // handshake hold-off: inputs churn while busy
    push_word(32'hC396_0FF0);
    data  = 32'hC396_0FF0;
    valid = 1'b1;
    tick();
    cyc        = 0;
    ready_hits = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      valid = (cyc < WORD_CYC - 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      data  = $urandom;
      if (ready === 1'b1) ready_hits++;
      cyc++;
      tick();
    end
    valid = 1'b0;
    check("holdoff_cycles", cyc, WORD_CYC);
    check("holdoff_ready_low", ready_hits, 0);
    repeat (2 * BYTE_CYC) tick();
    check("holdoff_no_second", busy, 1'b0);
    check("holdoff_queue", exp_q.size(), 0);

    // single-byte instance and parity
    send8(8'h07, cyc, got, bit9);
    check("w8_07_cycles", cyc, BYTE_CYC);
    check("w8_07_bits", got, 8'h07);
`ifdef WORD_UART_TX_PARITY_EN
    check("w8_07_parity", bit9, 1'b1);
`else
    check("w8_07_stop", bit9, 1'b1);
`endif
    tick();
    send8(8'h03, cyc, got, bit9);
    check("w8_03_cycles", cyc, BYTE_CYC);
    check("w8_03_bits", got, 8'h03);
`ifdef WORD_UART_TX_PARITY_EN
    check("w8_03_parity", bit9, 1'b0);
`else
    check("w8_03_stop", bit9, 1'b1);
`endif
    check("w8_ready_after", ready8, 1'b1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
